// File: rtl/core_pkg.sv
// Shared definitions for the interrupt sequencer.
// Contents:
//   PC_W, VEC_BASE : default PC width and handler vector base address
//   isr_state_t    : sequencer FSM state encoding (S_IDLE .. S_RET)
//   idx_width()    : index width for an n-entry encoder (at least 1 bit)
package core_pkg;

    localparam int PC_W = 12;
    localparam logic [PC_W-1:0] VEC_BASE = 12'h100;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_FLUSH = 3'd2,
        S_ISR   = 3'd3,
        S_RET   = 3'd4
    } isr_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index 0 is the highest priority.
// Ports:
//   req   in  N      request vector
//   valid out 1      at least one request set
//   index out IDX_W  index of the lowest set request (0 when none)
module irq_prio_enc
    import core_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // seen[k] is set when any request below index k is active; a bit is
    // granted only if nothing of higher priority is requesting.
    logic [N:0]   seen;
    logic [N-1:0] grant;

    assign seen[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chain
            assign seen[gi+1] = seen[gi] | req[gi];
            assign grant[gi]  = req[gi] & ~seen[gi];
        end
    endgenerate

    assign valid = seen[N];

    // grant is one-hot (or zero), so OR-ing the indices is exact.
    always_comb begin
        index = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                index = index | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/isr_sequencer.sv
// Interrupt sequencer for the 5-stage pipeline. Latches edge-triggered IRQs,
// picks the highest-priority enabled one, waits for a quiet pipeline, then
// flushes and redirects to the handler vector. URET flushes again and
// returns to the saved PC. No nesting.
// Ports:
//   clk, rst (async, active-high)
//   irq[NUM_IRQ], gie, mask_wr_en, mask_wr_data[NUM_IRQ]
//   id_pc[PC_W], id_valid, if_stall, exe_stall, branch_flush, jump_flush,
//   exe_is_uret
//   isr_pc_flush, isr_pipe_flush, isr_redirect, isr_redirect_pc[PC_W],
//   isr_ack[NUM_IRQ] (one-hot pulse), in_isr, irq_mask[NUM_IRQ]
module isr_sequencer
    import core_pkg::*;
#(
    parameter int                       NUM_IRQ    = 4,
    parameter int                       PC_W       = core_pkg::PC_W,
    parameter logic [core_pkg::PC_W-1:0] VEC_BASE  = core_pkg::VEC_BASE,
    parameter int                       VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               gie,
    input  logic               mask_wr_en,
    input  logic [NUM_IRQ-1:0] mask_wr_data,
    input  logic [PC_W-1:0]    id_pc,
    input  logic               id_valid,
    input  logic               if_stall,
    input  logic               exe_stall,
    input  logic               branch_flush,
    input  logic               jump_flush,
    input  logic               exe_is_uret,
    output logic               isr_pc_flush,
    output logic               isr_pipe_flush,
    output logic               isr_redirect,
    output logic [PC_W-1:0]    isr_redirect_pc,
    output logic [NUM_IRQ-1:0] isr_ack,
    output logic               in_isr,
    output logic [NUM_IRQ-1:0] irq_mask
);

    localparam int IDX_W = idx_width(NUM_IRQ);

    isr_state_t         state_reg, state_next;
    logic [NUM_IRQ-1:0] irq_d_reg;
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] mask_reg;
    logic [IDX_W-1:0]   cur_id_reg;
    logic [PC_W-1:0]    saved_pc_reg;

    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] clear_vec;
    logic               req_any;
    logic [IDX_W-1:0]   win_idx;
    logic               quiet;
    logic               take_irq;

    assign req      = pending_reg & mask_reg & {NUM_IRQ{gie}};
    assign quiet    = ~if_stall & ~exe_stall & ~branch_flush & ~jump_flush & id_valid;
    assign take_irq = (state_reg == S_WAIT) && req_any && quiet;
    assign irq_mask = mask_reg;

    irq_prio_enc #(
        .N     (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req   (req),
        .valid (req_any),
        .index (win_idx)
    );

    // The serviced bit is cleared on leaving FLUSH; a new edge on the same
    // bit in that cycle is OR-ed in afterwards so it is not lost.
    always_comb begin
        clear_vec = '0;
        if (state_reg == S_FLUSH) begin
            clear_vec = NUM_IRQ'(1) << cur_id_reg;
        end
        pending_next = (pending_reg & ~clear_vec) | (irq & ~irq_d_reg);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (req_any) state_next = S_WAIT;
            S_WAIT: begin
                if (!req_any)   state_next = S_IDLE;
                else if (quiet) state_next = S_FLUSH;
            end
            S_FLUSH: state_next = S_ISR;
            S_ISR:   if (exe_is_uret && !exe_stall) state_next = S_RET;
            S_RET:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            irq_d_reg    <= '0;
            pending_reg  <= '0;
            mask_reg     <= '1;
            cur_id_reg   <= '0;
            saved_pc_reg <= '0;
        end else begin
            state_reg   <= state_next;
            irq_d_reg   <= irq;
            pending_reg <= pending_next;
            if (mask_wr_en) begin
                mask_reg <= mask_wr_data;
            end
            // Priority is resolved here, so a late higher-priority request
            // arriving during WAIT still wins.
            if (take_irq) begin
                cur_id_reg   <= win_idx;
                saved_pc_reg <= id_pc;
            end
        end
    end

    // Moore outputs: decoded from state and registers only.
    always_comb begin
        isr_pc_flush    = 1'b0;
        isr_pipe_flush  = 1'b0;
        isr_redirect    = 1'b0;
        isr_redirect_pc = '0;
        isr_ack         = '0;
        in_isr          = 1'b0;
        case (state_reg)
            S_FLUSH: begin
                isr_pc_flush    = 1'b1;
                isr_pipe_flush  = 1'b1;
                isr_redirect    = 1'b1;
                isr_redirect_pc = VEC_BASE + PC_W'(VEC_STRIDE) * PC_W'(cur_id_reg);
                isr_ack         = NUM_IRQ'(1) << cur_id_reg;
            end
            S_ISR: in_isr = 1'b1;
            S_RET: begin
                isr_pc_flush    = 1'b1;
                isr_pipe_flush  = 1'b1;
                isr_redirect    = 1'b1;
                isr_redirect_pc = saved_pc_reg;
                in_isr          = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_isr_sequencer.sv
module tb_isr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic        gie;
    logic        mask_wr_en;
    logic [3:0]  mask_wr_data;
    logic [11:0] id_pc;
    logic        id_valid;
    logic        if_stall;
    logic        exe_stall;
    logic        branch_flush;
    logic        jump_flush;
    logic        exe_is_uret;
    logic        isr_pc_flush;
    logic        isr_pipe_flush;
    logic        isr_redirect;
    logic [11:0] isr_redirect_pc;
    logic [3:0]  isr_ack;
    logic        in_isr;
    logic [3:0]  irq_mask;

    isr_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .irq             (irq),
        .gie             (gie),
        .mask_wr_en      (mask_wr_en),
        .mask_wr_data    (mask_wr_data),
        .id_pc           (id_pc),
        .id_valid        (id_valid),
        .if_stall        (if_stall),
        .exe_stall       (exe_stall),
        .branch_flush    (branch_flush),
        .jump_flush      (jump_flush),
        .exe_is_uret     (exe_is_uret),
        .isr_pc_flush    (isr_pc_flush),
        .isr_pipe_flush  (isr_pipe_flush),
        .isr_redirect    (isr_redirect),
        .isr_redirect_pc (isr_redirect_pc),
        .isr_ack         (isr_ack),
        .in_isr          (in_isr),
        .irq_mask        (irq_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [11:0] pc;
        logic [3:0]  ack;
        logic        in_isr;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic push_ev(input logic [11:0] pc, input logic [3:0] ack, input logic ii, input int c);
        ev_t e;
        e.pc = pc; e.ack = ack; e.in_isr = ii; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_isr(input logic v, input string nm);
        int n = 0;
        while (in_isr !== v && n < 100) begin
            tick(1);
            n++;
        end
        chk(nm, 32'(in_isr), 32'(v));
    endtask

    // Pulse URET for one cycle; RET is visible in the following cycle.
    task automatic do_uret();
        exe_is_uret = 1'b1;
        tick(1);
        exe_is_uret = 1'b0;
    endtask

    // Monitor: every cycle the DUT shows a flush/redirect/ack, pop and compare.
    always @(negedge clk) begin
        if (!rst && (isr_redirect || isr_pc_flush || isr_pipe_flush || (|isr_ack))) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_redirect: got pc %0h ack %0h at cycle %0d expected no event",
                         isr_redirect_pc, isr_ack, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                $display("event cyc=%0d pc=%0h ack=%0h in_isr=%0b", cyc, isr_redirect_pc, isr_ack, in_isr);
                chk("ev_pc", 32'(isr_redirect_pc), 32'(e.pc));
                chk("ev_ack", 32'(isr_ack), 32'(e.ack));
                chk("ev_flags", 32'({isr_pc_flush, isr_pipe_flush, isr_redirect}), 32'(3'b111));
                chk("ev_in_isr", 32'(in_isr), 32'(e.in_isr));
                if (e.cyc >= 0) chk("ev_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic chk_outputs_idle(input string tag);
        chk({tag, "_in_isr"}, 32'(in_isr), 32'h0);
        chk({tag, "_flags"}, 32'({isr_pc_flush, isr_pipe_flush, isr_redirect}), 32'h0);
        chk({tag, "_ack"}, 32'(isr_ack), 32'h0);
        chk({tag, "_pc"}, 32'(isr_redirect_pc), 32'h0);
        chk({tag, "_mask"}, 32'(irq_mask), 32'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst = 1'b1; irq = '0; gie = 1'b1; mask_wr_en = 1'b0; mask_wr_data = '0;
        id_pc = 12'h040; id_valid = 1'b1; if_stall = 1'b0; exe_stall = 1'b0;
        branch_flush = 1'b0; jump_flush = 1'b0; exe_is_uret = 1'b0;
        tick(2);
        chk_outputs_idle("reset");
        rst = 1'b0;
        tick(2);

        // Single IRQ on line 1: FLUSH three cycles after the rising edge.
        c0 = cyc;
        irq = 4'b0010;
        push_ev(12'h104, 4'b0010, 1'b0, c0 + 3);
        tick(1);
        irq = '0;
        wait_isr(1'b1, "t2_enter");
        push_ev(12'h040, 4'b0000, 1'b1, cyc + 1);
        do_uret();
        tick(1);
        chk("t2_exit_in_isr", 32'(in_isr), 32'h0);
        tick(3);

        // Priority: lines 0 and 3 together; 0 first, 3 after one IDLE cycle.
        c0 = cyc;
        irq = 4'b1001;
        push_ev(12'h100, 4'b0001, 1'b0, c0 + 3);
        tick(1);
        irq = '0;
        wait_isr(1'b1, "t3_enter0");
        push_ev(12'h040, 4'b0000, 1'b1, cyc + 1);
        push_ev(12'h10C, 4'b1000, 1'b0, cyc + 4);
        do_uret();
        tick(3);
        wait_isr(1'b1, "t3_enter3");
        push_ev(12'h040, 4'b0000, 1'b1, cyc + 1);
        do_uret();
        tick(4);

        // Quiet gating: stall 5 cycles, branch flush 1 cycle, then quiet.
        c0 = cyc;
        push_ev(12'h108, 4'b0100, 1'b0, c0 + 7);
        for (int k = 0; k < 7; k++) begin
            id_pc        = 12'h200 + 12'(k);
            exe_stall    = (k < 5);
            branch_flush = (k == 5);
            irq          = (k == 0) ? 4'b0100 : 4'b0000;
            tick(1);
        end
        id_pc = 12'h040;
        wait_isr(1'b1, "t4_enter");
        push_ev(12'h206, 4'b0000, 1'b1, cyc + 1);
        do_uret();
        tick(4);

        // Mask: line 0 disabled, edge arrives, nothing happens until re-enabled.
        mask_wr_en = 1'b1; mask_wr_data = 4'b1110;
        tick(1);
        mask_wr_en = 1'b0;
        chk("t5_mask_written", 32'(irq_mask), 32'hE);
        irq = 4'b0001;
        tick(1);
        irq = '0;
        tick(6);
        chk("t5_masked_no_isr", 32'(in_isr), 32'h0);
        mask_wr_en = 1'b1; mask_wr_data = 4'hF;
        push_ev(12'h100, 4'b0001, 1'b0, cyc + 3);
        tick(1);
        mask_wr_en = 1'b0;
        wait_isr(1'b1, "t5_enter_after_unmask");
        push_ev(12'h040, 4'b0000, 1'b1, cyc + 1);
        do_uret();
        tick(4);

        // gie dropped during WAIT returns to IDLE: service resumes 2 cycles after gie.
        id_valid = 1'b0;
        irq = 4'b0100;
        tick(1);
        irq = '0;
        tick(3);
        gie = 1'b0;
        tick(2);
        id_valid = 1'b1;
        tick(3);
        chk("t5_gie_low_no_isr", 32'(in_isr), 32'h0);
        gie = 1'b1;
        push_ev(12'h108, 4'b0100, 1'b0, cyc + 2);
        wait_isr(1'b1, "t5_enter_after_gie");
        push_ev(12'h040, 4'b0000, 1'b1, cyc + 1);
        do_uret();
        tick(4);

        // Re-edge on line 1 during its own FLUSH: serviced again after RET.
        c0 = cyc;
        irq = 4'b0010;
        push_ev(12'h104, 4'b0010, 1'b0, c0 + 3);
        tick(1);
        irq = '0;
        tick(2);
        irq = 4'b0010;
        tick(1);
        irq = '0;
        wait_isr(1'b1, "t6_enter1");
        push_ev(12'h040, 4'b0000, 1'b1, cyc + 1);
        push_ev(12'h104, 4'b0010, 1'b0, cyc + 4);
        do_uret();
        tick(3);
        wait_isr(1'b1, "t6_enter2");
        push_ev(12'h040, 4'b0000, 1'b1, cyc + 1);
        do_uret();
        tick(5);

        // Reset mid-handler with another request pending and the mask altered.
        irq = 4'b0001;
        push_ev(12'h100, 4'b0001, 1'b0, cyc + 3);
        tick(1);
        irq = '0;
        wait_isr(1'b1, "t1_enter");
        mask_wr_en = 1'b1; mask_wr_data = 4'b1110;
        irq = 4'b1000;
        tick(1);
        mask_wr_en = 1'b0;
        irq = '0;
        tick(1);
        chk("t1_mask_before_reset", 32'(irq_mask), 32'hE);
        #2 rst = 1'b1;
        #1 chk_outputs_idle("t1_in_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        tick(8);
        chk("t1_after_reset_in_isr", 32'(in_isr), 32'h0);
        chk("t1_after_reset_mask", 32'(irq_mask), 32'hF);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
